// File: rtl/router_pkg.sv
// Shared types and constants for the router output-side scheduler.
// Holds the FSM state encoding, header field positions and the round-robin pick helper.
package router_pkg;

    localparam int NUM_PORTS    = 3;
    localparam int DATA_W       = 8;
    localparam int LEN_MSB      = 7;
    localparam int LEN_LSB      = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_REQ  = 2'd1,
        HDR_WAIT = 2'd2,
        BODY     = 2'd3
    } state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [1:0]        port;
        logic [DATA_W-1:0] data;
    } obuf_entry_t;

    // Search order is ptr+1, ptr+2, ptr; later loop passes overwrite, so the nearest wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [NUM_PORTS-1:0] req);
        logic [1:0] cand;
        rr_pick = ptr;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = 2'((int'(ptr) + k) % NUM_PORTS);
            if (req[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

endpackage

// File: rtl/rr_obuf.sv
// Two-entry tagged output buffer between the FIFO read path and the downstream link.
// Push and pop in the same cycle are allowed; the head fields read as zero when empty.
module rr_obuf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_sop_i,
    input  logic              push_eop_i,
    input  logic [1:0]        push_port_i,
    input  logic              pop_i,
    output logic [1:0]        occ_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_sop_o,
    output logic              head_eop_o,
    output logic [1:0]        head_port_o
);

    obuf_entry_t mem_q [2];
    obuf_entry_t head;
    logic        wr_q;
    logic        rd_q;
    logic [1:0]  cnt_q;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                wr_q <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

    // Payload storage carries no reset; the head is gated by the occupancy instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= '{sop: push_sop_i, eop: push_eop_i, port: push_port_i, data: push_data_i};
        end
    end

    assign valid_o     = (cnt_q != 2'd0);
    assign occ_o       = cnt_q;
    assign head        = valid_o ? mem_q[rd_q] : '0;
    assign head_data_o = head.data;
    assign head_sop_o  = head.sop;
    assign head_eop_o  = head.eop;
    assign head_port_o = head.port;

endmodule

// File: rtl/router_rr_drain.sv
// Packet-atomic round-robin drain of three router output FIFOs onto one byte link.
// Reads are throttled so buffered plus in-flight bytes never exceed the 2-entry buffer.
module router_rr_drain
    import router_pkg::*;
#(
    parameter int STALL_MAX  = 64,
    parameter int OBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vldout0,
    input  logic        vldout1,
    input  logic        vldout2,
    input  logic [7:0]  dout0,
    input  logic [7:0]  dout1,
    input  logic [7:0]  dout2,
    output logic        reen0,
    output logic        reen1,
    output logic        reen2,
    input  logic        link_ready,
    output logic        link_valid,
    output logic [7:0]  link_data,
    output logic        link_sop,
    output logic        link_eop,
    output logic [1:0]  link_port,
    output logic        pkt_drop
);

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [6:0]           rem_q, rem_d;
    logic [7:0]           stall_q, stall_d;
    logic                 infl_q, infl_sop_q, infl_eop_q;
    logic [1:0]           infl_port_q;

    logic [NUM_PORTS-1:0] vld;
    logic                 vld_g;
    logic [DATA_W-1:0]    rdata;
    logic [1:0]           occ;
    logic [2:0]           pending;
    logic                 pop;
    logic                 can_issue;
    logic                 issue;
    logic                 sop_t, eop_t;
    logic                 drop;

    assign vld = {vldout2, vldout1, vldout0};

    always_comb begin
        case (grant_q)
            2'd1:    vld_g = vldout1;
            2'd2:    vld_g = vldout2;
            default: vld_g = vldout0;
        endcase
        case (infl_port_q)
            2'd1:    rdata = dout1;
            2'd2:    rdata = dout2;
            default: rdata = dout0;
        endcase
    end

    // Slot accounting: a pop this cycle frees room for a read issued this cycle.
    assign pop       = link_valid && link_ready;
    assign pending   = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};
    assign can_issue = (pending < 3'(OBUF_DEPTH));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        stall_d = stall_q;
        issue   = 1'b0;
        sop_t   = 1'b0;
        eop_t   = 1'b0;
        drop    = 1'b0;

        if ((state_q == HDR_REQ) || (state_q == BODY)) begin
            issue   = vld_g && can_issue;
            stall_d = vld_g ? 8'd0 : stall_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                stall_d = 8'd0;
                if (|vld) begin
                    grant_d = rr_pick(ptr_q, vld);
                    state_d = HDR_REQ;
                end
            end
            HDR_REQ: begin
                if (issue) begin
                    sop_t   = 1'b1;
                    state_d = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                rem_d   = {1'b0, rdata[LEN_MSB:LEN_LSB]} + 7'd1;
                state_d = BODY;
            end
            BODY: begin
                if (issue) begin
                    rem_d = rem_q - 7'd1;
                    if (rem_q == 7'd1) begin
                        eop_t   = 1'b1;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The watchdog only fires on an empty cycle, so it never coincides with a read.
        if (((state_q == HDR_REQ) || (state_q == BODY)) && !vld_g &&
            (stall_q == 8'(STALL_MAX - 1))) begin
            drop    = 1'b1;
            ptr_d   = grant_q;
            stall_d = 8'd0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            ptr_q       <= 2'd2;
            rem_q       <= 7'd0;
            stall_q     <= 8'd0;
            infl_q      <= 1'b0;
            infl_sop_q  <= 1'b0;
            infl_eop_q  <= 1'b0;
            infl_port_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            stall_q     <= stall_d;
            infl_q      <= issue;
            infl_sop_q  <= sop_t;
            infl_eop_q  <= eop_t;
            infl_port_q <= grant_q;
        end
    end

    assign reen0    = issue && (grant_q == 2'd0);
    assign reen1    = issue && (grant_q == 2'd1);
    assign reen2    = issue && (grant_q == 2'd2);
    assign pkt_drop = drop;

    rr_obuf u_obuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (infl_q),
        .push_data_i (rdata),
        .push_sop_i  (infl_sop_q),
        .push_eop_i  (infl_eop_q),
        .push_port_i (infl_port_q),
        .pop_i       (pop),
        .occ_o       (occ),
        .valid_o     (link_valid),
        .head_data_o (link_data),
        .head_sop_o  (link_sop),
        .head_eop_o  (link_eop),
        .head_port_o (link_port)
    );

endmodule

// File: tb/tb_router_rr_drain.sv
// Bench for router_rr_drain: behavioural FIFOs feed the scheduler and a packet-level
// round-robin model predicts the exact tagged byte stream expected on the link.
module tb_router_rr_drain;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reen0, reen1, reen2;
    logic        link_ready = 1'b1;
    logic        link_valid;
    logic [7:0]  link_data;
    logic        link_sop, link_eop;
    logic [1:0]  link_port;
    logic        pkt_drop;
    logic [2:0]  vld_r = 3'b000;
    logic [7:0]  dout_r [3];

    logic [7:0]  fq [3][$];
    logic [11:0] exp_q [$];
    int          rd_port_log [$];
    int          rd_cyc_log [$];
    int          total = 0, bad = 0;
    int          cyc = 0, rd_total = 0, pop_total = 0, lost_base = 0;
    int          drops = 0, drop_cyc = 0, rdy_mode = 0, mptr = 2;
    logic [2:0]  rv;
    logic [11:0] word, hold_w;
    logic        hold_q = 1'b0;
    int          n_reen, outst;

    always #5 clk = ~clk;

    router_rr_drain dut (
        .clk        (clk),
        .rst        (rst),
        .vldout0    (vld_r[0]),
        .vldout1    (vld_r[1]),
        .vldout2    (vld_r[2]),
        .dout0      (dout_r[0]),
        .dout1      (dout_r[1]),
        .dout2      (dout_r[2]),
        .reen0      (reen0),
        .reen1      (reen1),
        .reen2      (reen2),
        .link_ready (link_ready),
        .link_valid (link_valid),
        .link_data  (link_data),
        .link_sop   (link_sop),
        .link_eop   (link_eop),
        .link_port  (link_port),
        .pkt_drop   (pkt_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Output FIFO model: 1-cycle read latency, non-empty flag updated at the read edge.
    initial begin
        for (int k = 0; k < 3; k++) dout_r[k] = 8'h00;
        forever begin
            @(posedge clk);
            rv = {reen2, reen1, reen0};
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    rd_total++;
                    rd_port_log.push_back(k);
                    rd_cyc_log.push_back(cyc);
                    chk("read_nonempty", fq[k].size() != 0, 1);
                    if (fq[k].size() != 0) dout_r[k] <= fq[k].pop_front();
                end
            end
            for (int k = 0; k < 3; k++) vld_r[k] <= (fq[k].size() != 0);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       link_ready = 1'b1;
                1:       link_ready = (cyc % 3 == 0);
                default: link_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Link monitor: stream order/tags, hold under back-pressure, read one-hot and slot bound.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_q = 1'b0;
            end else begin
                word = {link_port, link_sop, link_eop, link_data};
                if (hold_q) begin
                    chk("hold_valid", link_valid, 1);
                    chk("hold_word", word, hold_w);
                end
                n_reen = int'(reen0) + int'(reen1) + int'(reen2);
                if (n_reen != 0) begin
                    outst = rd_total + n_reen - pop_total - lost_base - int'(link_valid && link_ready);
                    chk("reen_onehot", n_reen, 1);
                    chk("outstanding_le2", outst <= 2, 1);
                end
                if (pkt_drop) begin
                    drops++;
                    drop_cyc = cyc;
                end
                if (link_valid && link_ready) begin
                    if (exp_q.size() == 0) chk("extra_link_byte", word, 12'hfff);
                    else chk("link_byte", word, exp_q.pop_front());
                    pop_total++;
                end
                hold_q = link_valid && !link_ready;
                hold_w = word;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "global timeout");
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_link_valid"}, link_valid, 0);
        chk({tag, "_reen"}, {reen2, reen1, reen0}, 0);
        chk({tag, "_link_data"}, link_data, 0);
        chk({tag, "_tags_drop"}, {link_sop, link_eop, link_port, pkt_drop}, 0);
    endtask

    task automatic do_reset(input string tag);
        sync();
        rst = 1'b1;
        #1;
        chk_outputs_zero(tag);
        for (int k = 0; k < 3; k++) fq[k].delete();
        exp_q.delete();
        mptr = 2;
        repeat (2) @(posedge clk);
        #2;
        lost_base = rd_total - pop_total;
        rst = 1'b0;
        sync();
    endtask

    task automatic add_pkt(input int port, input int len, input int dest);
        logic [7:0] hdr, b, par;
        hdr = 8'h00;
        hdr[LEN_MSB:LEN_LSB] = 6'(len);
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = 2'(dest);
        fq[port].push_back(hdr);
        par = hdr;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fq[port].push_back(b);
            par = par ^ b;
        end
        fq[port].push_back(par);
    endtask

    // Reference: whole packets leave in round-robin order starting after the last served port.
    task automatic plan();
        int pos [3];
        int sel, k, n;
        logic [7:0] hb;
        logic [1:0] pt;
        logic s, e;
        for (int j = 0; j < 3; j++) pos[j] = 0;
        forever begin
            sel = -1;
            for (int j = 1; j <= 3; j++) begin
                k = (mptr + j) % 3;
                if (sel < 0 && pos[k] < fq[k].size()) sel = k;
            end
            if (sel < 0) break;
            hb = fq[sel][pos[sel]];
            n  = int'(hb[7:2]) + 2;
            pt = 2'(sel);
            for (int i = 0; i < n; i++) begin
                s = (i == 0);
                e = (i == n - 1);
                exp_q.push_back({pt, s, e, fq[sel][pos[sel] + i]});
            end
            pos[sel] += n;
            mptr = sel;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || link_valid) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_fifos_empty"}, fq[0].size() + fq[1].size() + fq[2].size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        int d0, p0, n, bodies;
        logic [7:0] h1;
        rdy_mode = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        #1 rst = 1'b0;
        sync();

        // Port 1 alone, header 0x0D: five reads with one bubble after the header.
        rd_port_log.delete();
        rd_cyc_log.delete();
        fq[1].push_back(8'h0D);
        for (int i = 0; i < 4; i++) fq[1].push_back(8'(8'hA0 + i));
        plan();
        drain("t1");
        chk("t1_reads", rd_port_log.size(), 5);
        n = 0;
        foreach (rd_port_log[i]) if (rd_port_log[i] != 1) n++;
        chk("t1_other_reen", n, 0);
        if (rd_cyc_log.size() == 5) chk("t1_read_span", rd_cyc_log[4] - rd_cyc_log[0], 5);

        // Three ports loaded out of reset: grant order 0,1,2, no interleaving.
        do_reset("t2_rst");
        for (int p = 0; p < 3; p++) add_pkt(p, 2, p);
        plan();
        drain("t2");

        // Port 2 with L=0, then port 1 with L=63.
        add_pkt(2, 0, 3);
        plan();
        drain("t3a");
        add_pkt(1, 63, 0);
        plan();
        drain("t3b");

        // Port 0, L=5, with periodic back-pressure.
        rdy_mode = 1;
        add_pkt(0, 5, 2);
        plan();
        drain("t4");
        rdy_mode = 0;

        // Port 0 header only (L=10), port 1 packet pending: watchdog abandons port 0.
        do_reset("t5_rst");
        rd_port_log.delete();
        rd_cyc_log.delete();
        d0 = drops;
        fq[0].push_back(8'h28);
        add_pkt(1, 3, 1);
        exp_q.push_back({2'd0, 1'b1, 1'b0, 8'h28});
        for (int i = 0; i < fq[1].size(); i++) begin
            h1 = fq[1][i];
            exp_q.push_back({2'd1, i == 0, i == fq[1].size() - 1, h1});
        end
        mptr = 1;
        drain("t5");
        chk("t5_drop_count", drops - d0, 1);
        if (rd_cyc_log.size() != 0) begin
            chk("t5_first_read_port", rd_port_log[0], 0);
            chk("t5_drop_delay", (drop_cyc - rd_cyc_log[0] >= 64) && (drop_cyc - rd_cyc_log[0] <= 66), 1);
        end

        // Reset in the middle of a long body, then port 0 must win first.
        add_pkt(1, 40, 0);
        plan();
        p0 = pop_total;
        n = 0;
        while (pop_total - p0 < 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("t6_body_started", pop_total - p0 >= 5, 1);
        do_reset("t6_rst");
        rd_port_log.delete();
        rd_cyc_log.delete();
        for (int p = 0; p < 3; p++) add_pkt(p, 1 + p, 0);
        plan();
        drain("t6");
        if (rd_port_log.size() != 0) chk("t6_first_grant", rd_port_log[0], 0);

        // Randomized traffic under random back-pressure.
        rdy_mode = 2;
        bodies = 0;
        for (int it = 0; it < 12; it++) begin
            for (int p = 0; p < 3; p++) begin
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) begin
                    add_pkt(p, $urandom_range(0, 63), $urandom_range(0, 3));
                    bodies++;
                end
            end
            plan();
            drain("rand");
        end
        chk("total_drops", drops, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
